multi_pulse_generator: RTL and testbench

Programmable multi-channel pulse generator for TDC characterisation. On `start`, the block latches a frame period and, per channel, a delay and width. It then emits one pulse per channel per frame for a set number of frames, or continuously. It replaces the fixed two-pulse generator: the fixed spacing N becomes a per-channel run-time delay, and the block adds pulse width control, bursts, abort and status.

---
 rtl/multi_pulse_generator.sv | 201 ++++++++++++++++++++
 tb/tb_multi_pulse_generator.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_pulse_generator.sv
// -----------------------------------------------------------------------------
// multi_pulse_generator
//
// Programmable multi-channel pulse source for TDC characterisation. An accepted
// start latches a frame period, a burst length and, per channel, a delay, a
// pulse width and an enable. Each frame, channel i pulses high for width[i]
// cycles beginning delay[i] cycles after the frame start. The block runs for
// burst_count frames (0 = until stopped).
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous reset, active low
//   start        run request, honoured only while idle
//   stop         abort request, honoured in any state (wins over start)
//   period       frame length in cycles (must be >= 2)
//   burst_count  frames per run, 0 = continuous
//   delay        per-channel offset from frame start, channel i at [i*CW +: CW]
//   width        per-channel pulse width, channel i at [i*WW +: WW]
//   ch_enable    per-channel enable
//   pulse        registered pulse outputs
//   busy         high while a run is in progress
//   done         one-cycle strobe when a burst completes normally
//   cfg_err      one-cycle strobe when a start is rejected (period < 2)
//   frame_cnt    frames completed in the current or most recent run
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet, frame_cnt holds last result
// RUN   | phase counter sweeps 0..period-1 each frame, pulses generated
// -----------------------------------------------------------------------------
module multi_pulse_generator #(
    parameter int NCH = 4,
    parameter int CW  = 32,
    parameter int WW  = 8,
    parameter int BW  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [CW-1:0]     period,
    input  logic [BW-1:0]     burst_count,
    input  logic [NCH*CW-1:0] delay,
    input  logic [NCH*WW-1:0] width,
    input  logic [NCH-1:0]    ch_enable,
    output logic [NCH-1:0]    pulse,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [BW-1:0]     frame_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CW-1:0] CW_ONE = CW'(1);
    localparam logic [CW-1:0] CW_TWO = CW'(2);
    localparam logic [BW-1:0] BW_ONE = BW'(1);

    state_t              state_q,     state_d;
    logic [CW-1:0]       period_q,    period_d;
    logic [BW-1:0]       burst_q,     burst_d;
    logic [NCH*CW-1:0]   delay_q,     delay_d;
    logic [NCH*WW-1:0]   width_q,     width_d;
    logic [NCH-1:0]      enable_q,    enable_d;
    logic [CW-1:0]       phase_q,     phase_d;
    logic [BW-1:0]       frame_cnt_q, frame_cnt_d;
    logic [NCH-1:0]      pulse_q,     pulse_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                cfg_err_q,   cfg_err_d;

    logic                last_phase;
    logic [BW-1:0]       frame_next;

    // Window test done one bit wider than the phase so that delay + width can
    // never wrap around and re-open the window at small phases.
    function automatic logic chan_hit(
        input logic [CW-1:0] ph,
        input logic [CW-1:0] dly,
        input logic [WW-1:0] wid,
        input logic          en
    );
        logic [CW:0] ph_x;
        logic [CW:0] lo;
        logic [CW:0] hi;
        ph_x = {1'b0, ph};
        lo   = {1'b0, dly};
        hi   = lo + (CW+1)'(wid);
        return en && (ph_x >= lo) && (ph_x < hi);
    endfunction

    assign last_phase = (phase_q == (period_q - CW_ONE));
    assign frame_next = frame_cnt_q + BW_ONE;

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        burst_d     = burst_q;
        delay_d     = delay_q;
        width_d     = width_q;
        enable_d    = enable_q;
        phase_d     = phase_q;
        frame_cnt_d = frame_cnt_q;
        pulse_d     = '0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // stop has priority: a simultaneous start is dropped silently
                if (start && !stop) begin
                    if (period >= CW_TWO) begin
                        period_d    = period;
                        burst_d     = burst_count;
                        delay_d     = delay;
                        width_d     = width;
                        enable_d    = ch_enable;
                        phase_d     = '0;
                        frame_cnt_d = '0;
                        busy_d      = 1'b1;
                        state_d     = ST_RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (stop) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    for (int i = 0; i < NCH; i++) begin
                        pulse_d[i] = chan_hit(phase_q,
                                              delay_q[i*CW +: CW],
                                              width_q[i*WW +: WW],
                                              enable_q[i]);
                    end
                    if (last_phase) begin
                        phase_d     = '0;
                        frame_cnt_d = frame_next;
                        // burst_q == 0 is continuous; frame_cnt then wraps freely
                        if ((burst_q != '0) && (frame_next == burst_q)) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        phase_d = phase_q + CW_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            period_q    <= '0;
            burst_q     <= '0;
            delay_q     <= '0;
            width_q     <= '0;
            enable_q    <= '0;
            phase_q     <= '0;
            frame_cnt_q <= '0;
            pulse_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            burst_q     <= burst_d;
            delay_q     <= delay_d;
            width_q     <= width_d;
            enable_q    <= enable_d;
            phase_q     <= phase_d;
            frame_cnt_q <= frame_cnt_d;
            pulse_q     <= pulse_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign pulse     = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_multi_pulse_generator.sv
// -----------------------------------------------------------------------------
// tb_multi_pulse_generator
//
// Bench for multi_pulse_generator. A reference model computes the expected
// outputs from the run's elapsed cycle count with plain arithmetic (frame index
// and phase from division/modulo), a single compare process checks every
// output on every falling edge, and directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_multi_pulse_generator;

    localparam int NCH = 4;
    localparam int CW  = 32;
    localparam int WW  = 8;
    localparam int BW  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic [CW-1:0]     period;
    logic [BW-1:0]     burst_count;
    logic [NCH*CW-1:0] delay;
    logic [NCH*WW-1:0] width;
    logic [NCH-1:0]    ch_enable;
    logic [NCH-1:0]    pulse;
    logic              busy;
    logic              done;
    logic              cfg_err;
    logic [BW-1:0]     frame_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_pulse_generator #(.NCH(NCH), .CW(CW), .WW(WW), .BW(BW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .period      (period),
        .burst_count (burst_count),
        .delay       (delay),
        .width       (width),
        .ch_enable   (ch_enable),
        .pulse       (pulse),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .frame_cnt   (frame_cnt)
    );

    // ---------------- reference model ----------------
    // m_n counts edges since the accepting edge; after edge n the output pulse
    // reflects phase (n-1) mod P and frames completed equal n / P.
    bit     m_run = 1'b0;
    longint m_n, m_p, m_b;
    longint m_d [NCH];
    longint m_w [NCH];
    bit     m_en[NCH];

    logic [NCH-1:0] e_pulse = '0;
    logic           e_busy  = 1'b0;
    logic           e_done  = 1'b0;
    logic           e_cfg   = 1'b0;
    logic [BW-1:0]  e_fc    = '0;

    always @(posedge clk) begin : model
        longint ph;
        e_done = 1'b0;
        e_cfg  = 1'b0;
        if (!reset) begin
            m_run   = 1'b0;
            e_pulse = '0;
            e_busy  = 1'b0;
            e_fc    = '0;
        end else if (!m_run) begin
            e_pulse = '0;
            if (start && !stop) begin
                if (period >= 2) begin
                    m_p = longint'(period);
                    m_b = longint'(burst_count);
                    for (int i = 0; i < NCH; i++) begin
                        m_d[i]  = longint'(delay[i*CW +: CW]);
                        m_w[i]  = longint'(width[i*WW +: WW]);
                        m_en[i] = ch_enable[i];
                    end
                    m_run  = 1'b1;
                    m_n    = 0;
                    e_busy = 1'b1;
                    e_fc   = '0;
                end else begin
                    e_cfg = 1'b1;
                end
            end
        end else begin
            m_n = m_n + 1;
            if (stop) begin
                e_pulse = '0;
                e_busy  = 1'b0;
                m_run   = 1'b0;
                e_fc    = BW'((m_n - 1) / m_p);
            end else begin
                ph = (m_n - 1) % m_p;
                for (int i = 0; i < NCH; i++)
                    e_pulse[i] = m_en[i] && (ph >= m_d[i]) && (ph < m_d[i] + m_w[i]);
                e_fc = BW'(m_n / m_p);
                if (m_b > 0 && m_n == m_b * m_p) begin
                    e_done = 1'b1;
                    e_busy = 1'b0;
                    m_run  = 1'b0;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        checks++;
        if (pulse !== e_pulse) begin
            failures++;
            $display("FAIL pulse t=%0t act=%b exp=%b", $time, pulse, e_pulse);
        end
        checks++;
        if (busy !== e_busy) begin
            failures++;
            $display("FAIL busy t=%0t act=%b exp=%b", $time, busy, e_busy);
        end
        checks++;
        if (done !== e_done) begin
            failures++;
            $display("FAIL done t=%0t act=%b exp=%b", $time, done, e_done);
        end
        checks++;
        if (cfg_err !== e_cfg) begin
            failures++;
            $display("FAIL cfg_err t=%0t act=%b exp=%b", $time, cfg_err, e_cfg);
        end
        checks++;
        if (frame_cnt !== e_fc) begin
            failures++;
            $display("FAIL frame_cnt t=%0t act=%0d exp=%0d", $time, frame_cnt, e_fc);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse start for one edge; returns at the falling edge after E0.
    task automatic go();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic set_ch(input int i, input longint d, input longint w, input bit en);
        delay[i*CW +: CW] = CW'(d);
        width[i*WW +: WW] = WW'(w);
        ch_enable[i]      = en;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        period      = '0;
        burst_count = '0;
        delay       = '0;
        width       = '0;
        ch_enable   = '0;

        // reset / idle
        tick(3);
        reset = 1'b1;
        tick(1);
        chk("rst_pulse", pulse, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        tick(20);

        // basic burst
        period      = 10;
        burst_count = 3;
        set_ch(0, 0, 1, 1);
        set_ch(1, 3, 2, 1);
        set_ch(2, 9, 4, 1);
        set_ch(3, 12, 1, 1);
        go();                                   // E0
        chk("b_busy_e0", busy, 1);
        chk("b_pulse_e0", pulse, 0);
        tick(1);                                // E0+1
        chk("b_ch0_e1", pulse[0], 1);
        period    = 7;                          // must not disturb the latched run
        ch_enable = '0;
        tick(3);                                // E0+4
        chk("b_ch1_e4", pulse[1], 1);
        tick(1);                                // E0+5
        chk("b_ch1_e5", pulse[1], 1);
        tick(1);                                // E0+6
        chk("b_ch1_e6", pulse[1], 0);
        tick(4);                                // E0+10
        chk("b_ch2_e10", pulse[2], 1);
        chk("b_fc_e10", frame_cnt, 1);
        tick(1);                                // E0+11
        chk("b_ch0_e11", pulse[0], 1);
        chk("b_ch2_e11", pulse[2], 0);
        tick(19);                               // E0+30
        chk("b_done_e30", done, 1);
        chk("b_fc_e30", frame_cnt, 3);
        chk("b_busy_e30", busy, 0);
        chk("b_ch2_e30", pulse[2], 1);
        tick(1);                                // E0+31
        chk("b_pulse_e31", pulse, 0);
        chk("b_done_e31", done, 0);
        tick(2);

        // continuous + stop
        period      = 4;
        burst_count = 0;
        delay       = '0;
        width       = '0;
        ch_enable   = '0;
        set_ch(0, 0, 4, 1);
        go();
        tick(5);                                // E0+5
        chk("c_ch0_e5", pulse[0], 1);
        tick(4);                                // E0+9
        chk("c_ch0_e9", pulse[0], 1);
        stop = 1'b1;
        tick(1);                                // E0+10
        stop = 1'b0;
        chk("c_pulse_stop", pulse, 0);
        chk("c_busy_stop", busy, 0);
        chk("c_done_stop", done, 0);
        chk("c_fc_stop", frame_cnt, 2);
        tick(3);

        // illegal config and start+stop
        period      = 1;
        burst_count = 2;
        start       = 1'b1;
        tick(1);
        chk("i_cfg_err", cfg_err, 1);
        chk("i_busy", busy, 0);
        start = 1'b0;
        tick(1);
        chk("i_cfg_err_clr", cfg_err, 0);
        start = 1'b1;
        stop  = 1'b1;
        tick(1);
        chk("i_ss_cfg_err", cfg_err, 0);
        period = 10;
        tick(1);
        chk("i_ss_busy", busy, 0);
        start = 1'b0;
        stop  = 1'b0;
        tick(2);

        // reset mid-run, then restart
        period      = 6;
        burst_count = 5;
        set_ch(0, 2, 3, 1);
        go();
        tick(8);                                // second frame
        chk("r_busy_mid", busy, 1);
        chk("r_fc_mid", frame_cnt, 1);
        reset = 1'b0;
        tick(1);
        chk("r_pulse_rst", pulse, 0);
        chk("r_busy_rst", busy, 0);
        chk("r_fc_rst", frame_cnt, 0);
        reset = 1'b1;
        tick(2);
        period      = 3;
        burst_count = 2;
        set_ch(0, 1, 1, 1);
        go();
        tick(1);                                // E0+1, phase 0
        chk("r2_ch0_e1", pulse[0], 0);
        tick(1);                                // E0+2, phase 1
        chk("r2_ch0_e2", pulse[0], 1);
        tick(4);                                // E0+6
        chk("r2_done_e6", done, 1);
        chk("r2_fc_e6", frame_cnt, 2);
        tick(2);

        // re-trigger: start held through the run and the done cycle
        period      = 5;
        burst_count = 2;
        set_ch(0, 0, 1, 1);
        start = 1'b1;
        tick(1);                                // E0
        tick(10);                               // E0+10
        chk("t_done_e10", done, 1);
        chk("t_fc_e10", frame_cnt, 2);
        tick(1);                                // E0+11 = new E0
        chk("t_busy_new", busy, 1);
        chk("t_fc_new", frame_cnt, 0);
        start = 1'b0;
        tick(1);
        chk("t_ch0_new_e1", pulse[0], 1);
        tick(12);

        // randomized traffic, every cycle checked against the model
        for (int c = 0; c < 4000; c++) begin
            reset       = ($urandom_range(0, 299) != 0);
            start       = ($urandom_range(0, 5) == 0);
            stop        = ($urandom_range(0, 49) == 0);
            period      = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 1))
                                                      : CW'($urandom_range(2, 12));
            burst_count = BW'($urandom_range(0, 4));
            for (int i = 0; i < NCH; i++) begin
                delay[i*CW +: CW] = CW'($urandom_range(0, 14));
                width[i*WW +: WW] = ($urandom_range(0, 7) == 0) ? WW'($urandom_range(10, 255))
                                                                : WW'($urandom_range(0, 6));
                ch_enable[i]      = ($urandom_range(0, 3) != 0);
            end
            tick(1);
        end

        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
